bram_latency_mp: RTL

Multi-channel, latency-modelling block RAM used as a simulation/FPGA stand-in for slow memories (SDRAM, flash) behind the bus.
- Generalises the single-port fixed-latency model with:
  - N requester channels and round-robin arbitration.
  - Separate read and write latencies.
  - Byte-masked writes.
  - An explicit per-transaction state machine.
- Each channel uses the codebase's request/ready handshake: request held until ready.

---
 rtl/bram_latency_mp.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bram_latency_mp.sv
// Multi-channel block RAM that models slow-memory latency behind a request/ready bus.
// Optional build macro BRAM_LATENCY_JITTER_EN adds LFSR-driven random extra wait cycles.
module bram_latency_mp #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned SIZE          = 32'h400,
  parameter int unsigned ADDR_LSH      = 2,
  parameter int unsigned READ_LATENCY  = 10,
  parameter int unsigned WRITE_LATENCY = 4,
  parameter int unsigned JITTER_BITS   = 3
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic [CHANNELS-1:0]         i_request,
  input  logic [CHANNELS-1:0]         i_rw,
  input  logic [CHANNELS*32-1:0]      i_address,
  input  logic [CHANNELS*WIDTH-1:0]   i_wdata,
  input  logic [CHANNELS*WIDTH/8-1:0] i_wmask,
  output logic [CHANNELS*WIDTH-1:0]   o_rdata,
  output logic [CHANNELS-1:0]         o_ready,
  output logic [CHANNELS-1:0]         o_valid,
  output logic                        o_busy
);

  localparam int unsigned Bytes = WIDTH / 8;
  localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [15:0] JitterMask = 16'((32'd1 << JITTER_BITS) - 32'd1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q;
  logic [CW-1:0]     ptr_q;
  logic [CW-1:0]     grant_q;
  logic [31:0]       cnt_q;
  logic [31:0]       addr_q;
  logic              rw_q;
  logic [WIDTH-1:0]  wdata_q;
  logic [Bytes-1:0]  wmask_q;

  logic [WIDTH-1:0]  mem [SIZE];

  logic              found;
  logic [CW-1:0]     pick;
  logic [CW-1:0]     next_ptr;
  logic [31:0]       word;
  logic [AW-1:0]     word_idx;
  logic              in_range;
  logic              access;
  logic              mem_we;
  logic [15:0]       lfsr;
  logic [31:0]       jitter;

`ifdef BRAM_LATENCY_JITTER_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign lfsr = lfsr_q;
`else
  assign lfsr = 16'h0;
`endif

  assign jitter = {16'h0, lfsr & JitterMask};

  // Round-robin: first requesting channel at or after the pointer, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!found && i_request[(int'(ptr_q) + i) % CHANNELS]) begin
        found = 1'b1;
        pick  = CW'((int'(ptr_q) + i) % CHANNELS);
      end
    end
  end

  assign next_ptr = (grant_q == CW'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
  assign word     = addr_q >> ADDR_LSH;
  assign word_idx = word[AW-1:0];
  assign in_range = word < SIZE;
  assign access   = (state_q == StWait) && i_request[grant_q] && (cnt_q == 32'd0);
  assign mem_we   = access && rw_q && in_range;
  assign o_busy   = state_q != StIdle;

  always_ff @(posedge i_clock) begin
    if (mem_we) begin
      for (int b = 0; b < Bytes; b++) begin
        if (wmask_q[b]) mem[word_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      o_ready <= '0;
      o_valid <= '1;
      o_rdata <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= pick;
            addr_q  <= i_address[pick*32 +: 32];
            rw_q    <= i_rw[pick];
            wdata_q <= i_wdata[pick*WIDTH +: WIDTH];
            wmask_q <= i_wmask[pick*Bytes +: Bytes];
            cnt_q   <= (i_rw[pick] ? WRITE_LATENCY : READ_LATENCY) + jitter;
            state_q <= StWait;
          end
        end
        StWait: begin
          // A dropped request aborts without touching memory or the pointer
          if (!i_request[grant_q]) begin
            state_q <= StIdle;
          end else if (cnt_q != 32'd0) begin
            cnt_q <= cnt_q - 32'd1;
          end else begin
            o_ready[grant_q] <= 1'b1;
            o_valid[grant_q] <= in_range;
            if (!rw_q) begin
              o_rdata[grant_q*WIDTH +: WIDTH] <= in_range ? mem[word_idx] : '0;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          o_ready <= '0;
          ptr_q   <= next_ptr;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
